// File: rtl/wb_uart_master.sv
// UART-to-Wishbone debug bridge.
// A host sends 'W' + addr + data or 'R' + addr over an 8N1 serial link.
// The bridge performs one Wishbone classic transfer and answers with 'K',
// four read-data bytes, or 'E' when the slave errors or never acknowledges.
module wb_uart_master #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] C_BIT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_HALF     = CW'(CPB / 2 - 1);
    localparam logic [TW-1:0] C_TO_LAST  = TW'(ACK_TIMEOUT - 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

    // Receiver
    logic [2:0]    r_rxSync;
    rx_state_t     r_rxState;
    logic [CW-1:0] r_rxCnt;
    logic [2:0]    r_rxBitIdx;
    logic [7:0]    r_rxShift;
    logic          r_rxValid;
    logic          w_rxBit;

    // Transmitter
    logic [9:0]    r_txShift;
    logic          r_txBusy;
    logic [CW-1:0] r_txCnt;
    logic [3:0]    r_txBitIdx;
    logic          w_txLoad;
    logic [7:0]    w_txByte;

    // Command FSM and bus master
    state_t        r_state;
    state_t        w_nextState;
    logic          r_isWrite;
    logic [1:0]    r_byteCnt;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic [31:0]   r_rdBuf;
    logic          r_cyc;
    logic [TW-1:0] r_toCnt;
    logic          r_fail;
    logic [2:0]    r_respCnt;
    logic [2:0]    w_respLen;
    logic          w_cmdByte;
    logic          w_timeout;
    logic          w_busDone;

    assign w_rxBit   = r_rxSync[1];
    assign w_cmdByte = r_rxValid && ((r_rxShift == CMD_W) || (r_rxShift == CMD_R));
    assign w_timeout = r_cyc && (r_toCnt == C_TO_LAST);
    assign w_busDone = r_cyc && (wb_ack_i || wb_err_i || w_timeout);
    assign uart_tx_o = r_txShift[0];

    // Two-flop synchroniser for the serial input, plus one more stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxSync <= 3'b111;
        end else begin
            r_rxSync <= {r_rxSync[1:0], uart_rx_i};
        end
    end

    // Receive framer: start-bit recheck at half bit, mid-bit data sampling, stop-bit validation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxState  <= RX_IDLE;
            r_rxCnt    <= '0;
            r_rxBitIdx <= '0;
            r_rxShift  <= '0;
            r_rxValid  <= 1'b0;
        end else begin
            r_rxValid <= 1'b0;
            case (r_rxState)
                RX_IDLE: begin
                    if (r_rxSync[2] && !w_rxBit) begin
                        r_rxState <= RX_START;
                        r_rxCnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rxCnt == C_HALF) begin
                        r_rxCnt    <= '0;
                        r_rxBitIdx <= '0;
                        r_rxState  <= w_rxBit ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rxCnt == C_BIT_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxShift <= {w_rxBit, r_rxShift[7:1]};
                        if (r_rxBitIdx == 3'd7) begin
                            r_rxState <= RX_STOP;
                        end else begin
                            r_rxBitIdx <= r_rxBitIdx + 3'd1;
                        end
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rxCnt == C_BIT_LAST) begin
                        r_rxCnt <= '0;
                        if (w_rxBit) begin
                            r_rxValid <= 1'b1;
                            r_rxState <= RX_IDLE;
                        end else begin
                            r_rxState <= RX_WAIT;
                        end
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                RX_WAIT: begin
                    if (w_rxBit) begin
                        r_rxState <= RX_IDLE;
                    end
                end
                default: r_rxState <= RX_IDLE;
            endcase
        end
    end

    // Transmit shifter: frames a byte as start/8 data/stop and shifts it out LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txShift  <= '1;
            r_txBusy   <= 1'b0;
            r_txCnt    <= '0;
            r_txBitIdx <= '0;
        end else if (!r_txBusy) begin
            if (w_txLoad) begin
                r_txShift  <= {1'b1, w_txByte, 1'b0};
                r_txBusy   <= 1'b1;
                r_txCnt    <= '0;
                r_txBitIdx <= '0;
            end
        end else if (r_txCnt == C_BIT_LAST) begin
            r_txCnt   <= '0;
            r_txShift <= {1'b1, r_txShift[9:1]};
            if (r_txBitIdx == 4'd9) begin
                r_txBusy <= 1'b0;
            end else begin
                r_txBitIdx <= r_txBitIdx + 4'd1;
            end
        end else begin
            r_txCnt <= r_txCnt + CW'(1);
        end
    end

    // Command FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Command FSM next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_cmdByte) w_nextState = ADDR;
            ADDR:    if (r_rxValid && (r_byteCnt == 2'd3)) w_nextState = r_isWrite ? WDATA : BUS;
            WDATA:   if (r_rxValid && (r_byteCnt == 2'd3)) w_nextState = BUS;
            BUS:     if (w_busDone) w_nextState = RESP;
            RESP:    if ((r_respCnt == w_respLen) && !r_txBusy) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Field assembly, the single bus transfer with its timeout, and response byte counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_isWrite <= 1'b0;
            r_byteCnt <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rdBuf   <= '0;
            r_cyc     <= 1'b0;
            r_toCnt   <= '0;
            r_fail    <= 1'b0;
            r_respCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmdByte) begin
                        r_isWrite <= (r_rxShift == CMD_W);
                        r_byteCnt <= '0;
                    end
                end
                ADDR: begin
                    if (r_rxValid) begin
                        r_adr     <= {r_adr[23:0], r_rxShift};
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                WDATA: begin
                    if (r_rxValid) begin
                        r_dat     <= {r_dat[23:0], r_rxShift};
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                BUS: begin
                    if (!r_cyc) begin
                        r_cyc     <= 1'b1;
                        r_toCnt   <= '0;
                        r_respCnt <= '0;
                    end else if (wb_err_i) begin
                        r_cyc  <= 1'b0;
                        r_fail <= 1'b1;
                    end else if (wb_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_fail  <= 1'b0;
                        r_rdBuf <= wb_dat_i;
                    end else if (w_timeout) begin
                        r_cyc  <= 1'b0;
                        r_fail <= 1'b1;
                    end else begin
                        r_toCnt <= r_toCnt + TW'(1);
                    end
                end
                RESP: begin
                    if (w_txLoad) begin
                        r_respCnt <= r_respCnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs, busy flag and selection of the next response byte
    always_comb begin
        wb_cyc_o  = r_cyc;
        wb_stb_o  = r_cyc;
        wb_we_o   = r_cyc && r_isWrite;
        wb_sel_o  = r_cyc ? 4'hF : 4'h0;
        wb_adr_o  = r_adr;
        wb_dat_o  = r_dat;
        busy_o    = (r_state != IDLE) || r_txBusy;
        w_respLen = (r_fail || r_isWrite) ? 3'd1 : 3'd4;
        w_txLoad  = (r_state == RESP) && !r_txBusy && (r_respCnt < w_respLen);
        if (r_fail) begin
            w_txByte = RSP_E;
        end else if (r_isWrite) begin
            w_txByte = RSP_K;
        end else begin
            case (r_respCnt[1:0])
                2'd0:    w_txByte = r_rdBuf[31:24];
                2'd1:    w_txByte = r_rdBuf[23:16];
                2'd2:    w_txByte = r_rdBuf[15:8];
                default: w_txByte = r_rdBuf[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_master.sv
// Testbench for wb_uart_master: serial host driver, response decoder,
// Wishbone slave model, fixed vectors, randomized commands and corner sequences.
module tb_wb_uart_master;

    localparam int CLK_FREQ    = 1600;
    localparam int BAUD        = 100;
    localparam int CPB         = CLK_FREQ / BAUD;
    localparam int ACK_TIMEOUT = 16;
    localparam int BYTE_CYC    = 10 * CPB;

    localparam int M_ACK    = 0;
    localparam int M_ERR    = 1;
    localparam int M_ACKERR = 2;
    localparam int M_NONE   = 3;

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          mode;
        int          lat;
        logic [31:0] rdata;
        int          expLen;
        logic [31:0] expResp;
        int          expCycLen;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy_o;

    int compared = 0;
    int mismatched = 0;

    int          slaveMode = M_ACK;
    int          slaveLat = 1;
    logic [31:0] slaveData = 32'h0;
    int          xferCount = 0;
    int          cycLen = 0;
    bit          inCyc = 1'b0;
    logic [31:0] capAdr;
    logic [31:0] capDat;
    logic        capWe;
    logic [3:0]  capSel;
    logic        unstable;
    logic        busyInCyc;

    logic [7:0]  txQ[$];
    int          txFrameErr = 0;

    vec_t vecs[6];

    wb_uart_master #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx_i (uart_rx_i),
        .uart_tx_o (uart_tx_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    // Wishbone slave model: records each transfer and answers after slaveLat cycles
    initial begin
        forever begin
            @(negedge clk);
            if (wb_cyc_o && wb_stb_o) begin
                if (!inCyc) begin
                    inCyc     = 1'b1;
                    xferCount = xferCount + 1;
                    cycLen    = 0;
                    capAdr    = wb_adr_o;
                    capDat    = wb_dat_o;
                    capWe     = wb_we_o;
                    capSel    = wb_sel_o;
                    unstable  = 1'b0;
                    busyInCyc = busy_o;
                end else if (wb_adr_o !== capAdr || wb_dat_o !== capDat ||
                             wb_we_o !== capWe || wb_sel_o !== capSel) begin
                    unstable = 1'b1;
                end
                cycLen = cycLen + 1;
                if (slaveMode != M_NONE && cycLen == slaveLat) begin
                    wb_ack_i = (slaveMode != M_ERR);
                    wb_err_i = (slaveMode != M_ACK);
                    wb_dat_i = slaveData;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                    wb_dat_i = $urandom;
                end
            end else begin
                inCyc    = 1'b0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
            end
        end
    end

    // Serial decoder for the bridge's transmit line
    initial begin
        logic       txPrev;
        logic [7:0] byteV;
        txPrev = 1'b1;
        forever begin
            @(negedge clk);
            if (txPrev === 1'b1 && uart_tx_o === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                if (uart_tx_o === 1'b0) begin
                    for (int b = 0; b < 8; b++) begin
                        repeat (CPB) @(negedge clk);
                        byteV[b] = uart_tx_o;
                    end
                    repeat (CPB) @(negedge clk);
                    if (uart_tx_o === 1'b1) txQ.push_back(byteV);
                    else txFrameErr = txFrameErr + 1;
                end
            end
            txPrev = uart_tx_o;
        end
    end

    // Global time limit so the run can never hang
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_i = stopBit;
        repeat (CPB) @(negedge clk);
        uart_rx_i = 1'b1;
        if (!stopBit) repeat (CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] wdata);
        sendByte(isWrite ? 8'h57 : 8'h52, 1'b1);
        for (int i = 3; i >= 0; i--) sendByte(addr[i*8 +: 8], 1'b1);
        if (isWrite) begin
            for (int i = 3; i >= 0; i--) sendByte(wdata[i*8 +: 8], 1'b1);
        end
    endtask

    task automatic awaitResponse(input int expLen, output logic [31:0] resp, output int gotLen,
                                 output logic busyAtEnd, output logic busyAfter);
        int waited;
        waited = 0;
        while (txQ.size() < expLen && waited < 8 * BYTE_CYC) begin
            @(negedge clk);
            waited = waited + 1;
        end
        busyAtEnd = busy_o;
        repeat (CPB) @(negedge clk);
        busyAfter = busy_o;
        repeat (2 * BYTE_CYC) @(negedge clk);
        gotLen = txQ.size();
        resp = 32'h0;
        foreach (txQ[k]) resp = {resp[23:0], txQ[k]};
    endtask

    // Reference: response bytes follow from command type and how the slave answers
    function automatic void modelResponse(input logic isWrite, input int mode, input logic [31:0] rdata,
                                          output int len, output logic [31:0] resp);
        if (mode != M_ACK) begin
            len  = 1;
            resp = 32'h45;
        end else if (isWrite) begin
            len  = 1;
            resp = 32'h4B;
        end else begin
            len  = 4;
            resp = rdata;
        end
    endfunction

    task automatic runCheck(input string tag, input logic isWrite, input logic [31:0] addr,
                            input logic [31:0] wdata, input int mode, input int lat,
                            input logic [31:0] rdata, input int expLen, input logic [31:0] expResp,
                            input int expCycLen);
        logic [31:0] resp;
        int          gotLen;
        logic        busyAtEnd;
        logic        busyAfter;
        slaveMode = mode;
        slaveLat  = lat;
        slaveData = rdata;
        txQ.delete();
        xferCount = 0;
        applyStimulus(isWrite, addr, wdata);
        awaitResponse(expLen, resp, gotLen, busyAtEnd, busyAfter);
        checkOutput({tag, "_len"}, 32'(gotLen), 32'(expLen));
        checkOutput({tag, "_resp"}, resp, expResp);
        checkOutput({tag, "_xfers"}, 32'(xferCount), 32'd1);
        checkOutput({tag, "_adr"}, capAdr, addr);
        checkOutput({tag, "_we"}, 32'(capWe), 32'(isWrite));
        checkOutput({tag, "_sel"}, 32'(capSel), 32'hF);
        checkOutput({tag, "_stable"}, 32'(unstable), 32'd0);
        checkOutput({tag, "_busy_in_cyc"}, 32'(busyInCyc), 32'd1);
        checkOutput({tag, "_cyc_len"}, 32'(cycLen), 32'(expCycLen));
        if (isWrite) checkOutput({tag, "_dat"}, capDat, wdata);
        checkOutput({tag, "_busy_last_stop"}, 32'(busyAtEnd), 32'd1);
        checkOutput({tag, "_busy_after"}, 32'(busyAfter), 32'd0);
        checkOutput({tag, "_cyc_idle"}, 32'(wb_cyc_o), 32'd0);
        checkOutput({tag, "_sel_idle"}, 32'(wb_sel_o), 32'd0);
    endtask

    initial begin
        logic [31:0] resp;
        int          gotLen;
        logic        busyAtEnd;
        logic        busyAfter;
        logic        rIsWrite;
        logic [31:0] rAddr;
        logic [31:0] rData;
        logic [31:0] rRd;
        int          rMode;
        int          rLat;
        int          rLen;
        logic [31:0] rResp;
        int          waited;

        vecs[0] = '{1'b1, 32'h00000010, 32'hDEADBEEF, M_ACK,    3, 32'h0,        1, 32'h0000004B, 3};
        vecs[1] = '{1'b0, 32'h20000004, 32'h0,        M_ACK,    1, 32'h12345678, 4, 32'h12345678, 1};
        vecs[2] = '{1'b0, 32'h00001000, 32'h0,        M_NONE,   0, 32'h0,        1, 32'h00000045, 16};
        vecs[3] = '{1'b1, 32'h40000000, 32'hCAFEF00D, M_ACKERR, 2, 32'h0,        1, 32'h00000045, 2};
        vecs[4] = '{1'b0, 32'h80000003, 32'h0,        M_ERR,    4, 32'h0,        1, 32'h00000045, 4};
        vecs[5] = '{1'b1, 32'h00000001, 32'h00000000, M_ACK,    1, 32'h0,        1, 32'h0000004B, 1};

        $display("[TB] reset");
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(uart_tx_o), 32'd1);
        checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
        checkOutput("rst_we", 32'(wb_we_o), 32'd0);
        checkOutput("rst_sel", 32'(wb_sel_o), 32'd0);
        checkOutput("rst_adr", wb_adr_o, 32'd0);
        checkOutput("rst_dat", wb_dat_o, 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] fixed vectors");
        for (int i = 0; i < 6; i++) begin
            runCheck($sformatf("vec%0d", i), vecs[i].isWrite, vecs[i].addr, vecs[i].wdata,
                     vecs[i].mode, vecs[i].lat, vecs[i].rdata, vecs[i].expLen,
                     vecs[i].expResp, vecs[i].expCycLen);
        end

        $display("[TB] unknown byte before read");
        txQ.delete();
        sendByte(8'h41, 1'b1);
        repeat (2 * BYTE_CYC) @(negedge clk);
        checkOutput("unk_noresp", 32'(txQ.size()), 32'd0);
        checkOutput("unk_busy", 32'(busy_o), 32'd0);
        runCheck("unk_read", 1'b0, 32'h30000008, 32'h0, M_ACK, 2, 32'hA5A55A5A, 4, 32'hA5A55A5A, 2);

        $display("[TB] framing error on address byte");
        slaveMode = M_ACK;
        slaveLat  = 1;
        slaveData = 32'h0BADF00D;
        txQ.delete();
        xferCount = 0;
        sendByte(8'h52, 1'b1);
        sendByte(8'h11, 1'b0);
        sendByte(8'h11, 1'b1);
        sendByte(8'h22, 1'b1);
        sendByte(8'h33, 1'b1);
        sendByte(8'h44, 1'b1);
        awaitResponse(4, resp, gotLen, busyAtEnd, busyAfter);
        checkOutput("frm_len", 32'(gotLen), 32'd4);
        checkOutput("frm_resp", resp, 32'h0BADF00D);
        checkOutput("frm_adr", capAdr, 32'h11223344);
        checkOutput("frm_xfers", 32'(xferCount), 32'd1);

        $display("[TB] quarter-bit glitch inside address");
        slaveData = 32'h600DCAFE;
        txQ.delete();
        xferCount = 0;
        sendByte(8'h52, 1'b1);
        sendByte(8'hAA, 1'b1);
        sendByte(8'hBB, 1'b1);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        sendByte(8'hCC, 1'b1);
        sendByte(8'hDD, 1'b1);
        awaitResponse(4, resp, gotLen, busyAtEnd, busyAfter);
        checkOutput("glitch_len", 32'(gotLen), 32'd4);
        checkOutput("glitch_resp", resp, 32'h600DCAFE);
        checkOutput("glitch_adr", capAdr, 32'hAABBCCDD);

        $display("[TB] reset during transfer");
        slaveMode = M_NONE;
        txQ.delete();
        applyStimulus(1'b0, 32'h50000000, 32'h0);
        waited = 0;
        while (!wb_cyc_o && waited < 4 * CPB) begin
            @(negedge clk);
            waited = waited + 1;
        end
        checkOutput("rstx_cyc_before", 32'(wb_cyc_o), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstx_cyc", 32'(wb_cyc_o), 32'd0);
        checkOutput("rstx_stb", 32'(wb_stb_o), 32'd0);
        checkOutput("rstx_sel", 32'(wb_sel_o), 32'd0);
        checkOutput("rstx_tx", 32'(uart_tx_o), 32'd1);
        checkOutput("rstx_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BYTE_CYC) @(negedge clk);
        checkOutput("rstx_noresp", 32'(txQ.size()), 32'd0);
        runCheck("rstx_read", 1'b0, 32'h50000000, 32'h0, M_ACK, 2, 32'h89ABCDEF, 4, 32'h89ABCDEF, 2);

        $display("[TB] randomized commands");
        for (int i = 0; i < 10; i++) begin
            rIsWrite = 1'($urandom_range(0, 1));
            rAddr    = $urandom;
            rData    = $urandom;
            rRd      = $urandom;
            rLat     = $urandom_range(1, 6);
            case ($urandom_range(0, 5))
                3:       rMode = M_ERR;
                4:       rMode = M_ACKERR;
                5:       rMode = M_NONE;
                default: rMode = M_ACK;
            endcase
            modelResponse(rIsWrite, rMode, rRd, rLen, rResp);
            runCheck($sformatf("rnd%0d", i), rIsWrite, rAddr, rData, rMode, rLat, rRd,
                     rLen, rResp, (rMode == M_NONE) ? ACK_TIMEOUT : rLat);
        end

        checkOutput("tx_frame_errors", 32'(txFrameErr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_uart_master.md
Name: wb_uart_master

Overview:
- UART-to-Wishbone debug bridge. It acts as a bus initiator and drives the spare conmax master port (m2, the xwb_* wires).
- A host PC issues single 32-bit reads and writes to any slave: on-chip RAM, SDRAM, GPIO.
- It contains its own 8N1 UART receiver and transmitter, a command parser FSM and a single-transfer Wishbone classic master with an ack timeout.

Parameters:
- CLK_FREQ, 50000000: bus clock frequency in Hz.
- BAUD, 115200: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer truncated (434 at defaults).
- ACK_TIMEOUT, 1024: maximum number of cycles the master waits for ack or err before it aborts.

Ports:
- clk  in  1  bus clock (clk_bus).
- rst_n  in  1  reset, asynchronous, active-low.
- uart_rx_i  in  1  serial input from host; asynchronous to clk.
- uart_tx_o  out  1  serial output to host.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte selects.
- wb_adr_o  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  transfer acknowledge.
- wb_err_i  in  1  transfer error.
- busy_o  out  1  high from the first address byte until the last response byte has left the shifter.

Behaviour:
- Reset (asynchronous, immediate):
  - uart_tx_o=1; wb_cyc_o=wb_stb_o=wb_we_o=0; wb_sel_o=0; wb_adr_o=0; wb_dat_o=0; busy_o=0.
  - FSM goes to IDLE; RX/TX shifters and all counters clear.
  - Reset asserted mid-transfer drops cyc/stb in the same instant. No response is sent.
- RX:
  - uart_rx_i passes through a 2-flop synchroniser.
  - A falling edge in idle starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the frame is a glitch, is discarded, and RX returns to idle.
  - 8 data bits are sampled LSB first at mid-bit.
  - Stop bit: if 0, the byte is dropped (framing error) and RX waits for the line to return high.
  - A valid byte produces a 1-cycle rx_valid pulse.
- TX:
  - 8N1, LSB first; the line is idle high.
  - Each byte takes 10*CLKS_PER_BIT cycles.
  - The FSM loads the next byte only when the transmitter is idle.
- Command protocol (multi-byte fields MSB first):
  - 0x57 'W' + 4 address bytes + 4 data bytes -> response 0x4B 'K'.
  - 0x52 'R' + 4 address bytes -> response of 4 data bytes.
  - Any bus failure -> single response byte 0x45 'E', for either command. A read sends no data bytes on failure.
  - Any other byte received in IDLE is ignored; no response.
- FSM states: IDLE, ADDR, WDATA, BUS, RESP.
  - IDLE: on 'W'/'R', latch we and go to ADDR.
  - ADDR: shift 4 bytes into wb_adr_o. For a write go to WDATA, for a read go to BUS.
  - WDATA: shift 4 bytes into wb_dat_o, then go to BUS.
  - BUS: see Wishbone rules below.
  - RESP: send the response bytes, then return to IDLE.
  - Bytes received during BUS or RESP are dropped; the host must wait for the response.
- Wishbone rules:
  - wb_cyc_o and wb_stb_o rise together on the cycle after BUS is entered. wb_sel_o=4'hF for the whole transfer.
  - Signals are held stable until wb_ack_i, wb_err_i or timeout.
  - On the ack cycle, wb_dat_i is latched into the read buffer. cyc/stb/we drop on the next edge; exactly one transfer per command.
  - If ack and err are both high, err wins.
  - Timeout counter: starts at 0 on the cycle stb rises. On reaching ACK_TIMEOUT-1 with no ack/err, the transfer aborts and 'E' is sent.
  - After completion, wb_sel_o returns to 0. wb_adr_o and wb_dat_o keep their last values.
- Address alignment: addresses are passed through unaligned; the slave decides the behaviour.

Test Plan:
- Write: send 57 00 00 00 10 DE AD BE EF, with a slave model acking after 3 cycles -> exactly one cycle with adr=0x00000010, dat=0xDEADBEEF, we=1, sel=F; then TX byte 0x4B. busy_o falls after the stop bit of that byte.
- Read: send 52 20 00 00 04, with slave returning 0x12345678 on ack -> TX bytes 12 34 56 78; we=0 throughout the cycle.
- Timeout: read from a non-acking slave with ACK_TIMEOUT=16 -> cyc high for exactly 16 cycles, then TX 0x45 only.
- Error handling:
  - wb_err_i and wb_ack_i asserted together on a write -> TX 0x45.
  - Unknown byte 0x41 sent before a valid read -> 0x41 ignored; the read completes normally.
- Robustness:
  - Framing error injected on an address byte (stop bit 0) -> that byte is not counted; a correct resend completes the command.
  - 1/4-bit low glitch on uart_rx_i -> no byte is received.
- Reset mid-transfer: assert rst_n=0 while cyc=1 -> cyc/stb go to 0 immediately and uart_tx_o=1. After release, a fresh 'R' command works.
